divisor_sequencial: RTL
=======================

// Module: divisor_sequencial
// PURPOSE
//  Sequential restoring divider: unsigned WA-bit dividend A / WB-bit divisor B -> quotient Q, remainder R.
//  Companion to the shift-and-add multiplier: same Start/Done-style control, one quotient bit per clock.
//  Holds results in registers until the next operation. Serves the arithmetic datapath wherever the
//  product must be reversed (Q*B + R == A).
// PARAMETERS
//  WA  16  dividend and quotient width (iteration count = WA)
//  WB   8  divisor and remainder width
// PORTS
//  Clk      in   1   clock, rising edge
//  Rst      in   1   asynchronous, active-high reset
//  Start    in   1   request; sampled only in IDLE or DONE
//  A        in   WA  dividend, latched on accepted Start
//  B        in   WB  divisor, latched on accepted Start
//  Q        out  WA  quotient
//  R        out  WB  remainder
//  Busy     out  1   high while in CALC
//  Done     out  1   high while in DONE (results valid)
//  DivZero  out  1   high with Done when the latched B was 0
// BEHAVIOUR
//  Reset (async, Rst=1): state=IDLE; Q=0, R=0, Busy=0, Done=0, DivZero=0; internal regs and counter cleared.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: Start=1 at an edge -> latch A,B; counter=0; partial remainder P(WB+1 bits)=0; go to CALC.
//         If B==0 at that edge -> go straight to DONE: Q=all ones, R=A[WB-1:0], DivZero=1.
//   CALC: every edge performs one restoring step, MSB first:
//         P' = {P[WB-1:0], dividend MSB}; dividend shifts left 1;
//         if P' >= {1'b0,B}: P = P' - B, quotient bit = 1; else P = P', bit = 0;
//         quotient bit shifts into Q LSB. Counter increments.
//         After the WA-th step (counter = WA-1 at that edge) -> DONE; R = P[WB-1:0].
//         Start is ignored in CALC; A/B changes are ignored (latched copies used).
//   DONE: Done=1, Q/R/DivZero stable. Start=1 -> same action as from IDLE (back-to-back allowed),
//         Done drops on that edge. Otherwise stays in DONE indefinitely.
//  Latency: Done rises on the WA-th edge after the edge that accepted Start (16 at defaults);
//   divide-by-zero: Done on the edge after Start, i.e. 1 edge.
//  Busy=1 exactly in CALC; Busy and Done never high together.
//  Q, R are not updated to intermediate values visible as "valid": Q may change during CALC,
//   but consumers read only when Done=1. DivZero cleared when a new operation is accepted.
//  Width rules: all unsigned; P is WB+1 bits so subtraction never overflows; result exact:
//   Q*B + R == A and R < B whenever B != 0.
//  Rst asserted mid-CALC: immediate abort to reset values; no partial result retained;
//   next Start after Rst release starts a fresh operation.
//  Start and Rst simultaneous: Rst wins.
// TESTING
//  1) A=1000, B=7, Start 1 cycle -> Busy for 16 cycles, then Done=1, Q=142, R=6, DivZero=0.
//  2) A=65535, B=255 -> Q=257, R=0; A=5, B=9 -> Q=0, R=5; A=0, B=1 -> Q=0, R=0.
//  3) A=0x1234, B=0 -> Done 1 edge after Start, DivZero=1, Q=0xFFFF, R=0x34, Busy never high.
//  4) Start pulses during CALC plus A/B changed mid-op -> ignored; result matches originally latched operands.
//  5) Rst=1 at step 8 of A=1000/B=7 -> all outputs 0 immediately; new Start A=100,B=10 -> Q=10, R=0.
//  6) Back-to-back: Start held high in DONE with new A=300,B=17 -> Done drops next edge, Q=17, R=11 after 16 edges;
//     plus random sweep (1000 vectors) checked against Q*B+R==A, R<B.

Source files
------------

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: unsigned WA-bit dividend / WB-bit divisor,
// one quotient bit per clock, MSB first. Results are held until the next
// accepted Start; divide-by-zero completes in a single edge.
module divisor_sequencial #(
  parameter int WA = 16,
  parameter int WB = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic [WA-1:0] Q,
  output logic [WB-1:0] R,
  output logic          Busy,
  output logic          Done,
  output logic          DivZero
);

  localparam int CW = (WA > 1) ? $clog2(WA) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [WA-1:0] dvd;     // latched dividend, shifted left each step
  logic [WB-1:0] dvs;     // latched divisor
  logic [WB:0]   p;       // partial remainder, one spare bit for the compare
  logic [CW-1:0] cnt;     // step counter

  logic [WB:0]   p_sh;
  logic [WB:0]   p_sub;
  logic          q_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    p_sh  = (p << 1) | (WB+1)'(dvd[WA-1]);
    q_bit = (p_sh >= {1'b0, dvs});
    p_sub = q_bit ? (p_sh - {1'b0, dvs}) : p_sh;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dvs     <= '0;
      p       <= '0;
      cnt     <= '0;
      Q       <= '0;
      R       <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            dvd <= A;
            dvs <= B;
            cnt <= '0;
            p   <= '0;
            if (B == '0) begin
              // Zero divisor bypasses CALC entirely.
              Q       <= '1;
              R       <= A[WB-1:0];
              DivZero <= 1'b1;
              Busy    <= 1'b0;
              Done    <= 1'b1;
              state   <= DONE;
            end else begin
              Q       <= '0;
              DivZero <= 1'b0;
              Busy    <= 1'b1;
              Done    <= 1'b0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          p   <= p_sub;
          Q   <= {Q[WA-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WA - 1)) begin
            R     <= p_sub[WB-1:0];
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
